bp_line_store: RTL and testbench
================================

BP_LINE_STORE -- requirements
Module: bp_line_store

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, lookup/write address width.
REQ-002 SHALL have parameter DWIDTH, default 32, payload width.
REQ-003 SHALL have parameter LINES, default 128, number of lines, power of two, minimum 2.
REQ-004 SHALL derive INDEXWIDTH=clog2(LINES), TAGWIDTH=AWIDTH-INDEXWIDTH, ENTRYWIDTH=DWIDTH+TAGWIDTH+1, CACHEWIDTH=1+2*ENTRYWIDTH.
REQ-005 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high when the array is cleared and accepting traffic.
- ra0  in  AWIDTH  read port 0 address.
- re0  in  1  read port 0 lookup qualifier; affects statistics only.
- dout0  out  DWIDTH  read port 0 payload.
- hit0  out  1  read port 0 hit.
- ra1  in  AWIDTH  read port 1 address.
- re1  in  1  read port 1 lookup qualifier; affects statistics only.
- dout1  out  DWIDTH  read port 1 payload.
- hit1  out  1  read port 1 hit.
- wa  in  AWIDTH  write-side address; selects the line.
- line_out  out  CACHEWIDTH  current line at wa[INDEXWIDTH-1:0], fed to the external merge logic.
- we  in  1  write enable.
- line_in  in  CACHEWIDTH  merged line to store at wa index.

Function
REQ-006 Line format SHALL be {fifo_flag, entry2, entry1}; entry = {data[DWIDTH], tag[TAGWIDTH], valid}; valid at bit 0.
REQ-007 Index SHALL be addr[INDEXWIDTH-1:0]; tag SHALL be addr[AWIDTH-1:INDEXWIDTH].
REQ-008 Reads SHALL be combinational (zero latency) from the array on both ports.
REQ-009 hitN SHALL be ready AND (entry1 valid with tag match OR entry2 valid with tag match).
REQ-010 doutN SHALL be entry1 data if entry1 hits, else entry2 data if entry2 hits, else 0; entry1 wins if both hit.
REQ-011 line_out SHALL be combinational from the array and SHALL be all-zero while ready=0.
REQ-012 Write SHALL occur on the clock edge when we=1 and ready=1; we SHALL be ignored while ready=0.
REQ-013 A read or line_out access to the line being written in the same cycle SHALL return the old contents; new contents SHALL be visible the following cycle (no bypass).
REQ-014 FSM states SHALL be CLEAR and RUN. CLEAR writes zero to line clr_idx and increments clr_idx each cycle. After writing line LINES-1, the FSM SHALL move to RUN. RUN is held until rst.
REQ-015 ready SHALL be 1 exactly in RUN, so it rises LINES cycles after the rst deassertion edge.
REQ-016 clr_idx SHALL wrap by width and SHALL never exceed LINES-1.

Reset
REQ-017 rst=1 SHALL force the FSM to CLEAR, clr_idx=0 and ready=0; array clearing SHALL begin with the first cycle rst=0.
REQ-018 rst asserted mid-CLEAR or in RUN SHALL restart the sweep from line 0.
REQ-019 While ready=0, outputs SHALL be: hit0=hit1=0, dout0=dout1=0, line_out=0.

Configuration
REQ-020 With BP_LINE_STORE_STATS_EN defined, the block SHALL add 32-bit outputs lookups and hits. Each cycle with ready=1, lookups SHALL increment by re0+re1 and hits by (re0&hit0)+(re1&hit1). Both counters SHALL saturate at 2^32-1 and reset to 0 on rst.
REQ-021 Without BP_LINE_STORE_STATS_EN, the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-022 rst high 3 cycles then low, LINES=128 -> ready=0 for 128 cycles, then ready=1; a read of any address gives hit=0, dout=0.
REQ-023 we=1, wa=0x0000_0085, line_in with entry1={data 0xDEAD_BEEF, tag 0x1, valid 1} -> same cycle hit0=0; next cycle ra0=0x85 gives hit0=1, dout0=0xDEADBEEF, and ra1=0x105 gives hit1=0.
REQ-024 Line 5 holds entry1 with tag 1 / 0x11 and entry2 with tag 2 / 0x22 -> ra0=0x85 gives 0x11, ra1=0x105 gives 0x22, both hits the same cycle; line_out at wa=0x105 equals the stored line.
REQ-025 rst pulsed 1 cycle at sweep cycle 60 -> ready stays 0 for 128 cycles after deassertion; a we issued during the sweep does not alter the array.
REQ-026 With STATS_EN: 10 cycles with re0=re1=1, port 0 hitting and port 1 missing -> lookups=20, hits=10; preload hits=0xFFFF_FFFF then one hit -> hits stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/bp_line_store.sv
`default_nettype none
// ============================================================================
// Module   : bp_line_store
// Brief    : Two-way line array with dual combinational lookup ports, a
//            read-modify-write line port, and a clear sweep after reset.
//            Optional statistics counters under `BP_LINE_STORE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module bp_line_store #(
    parameter  int AWIDTH     = 32,
    parameter  int DWIDTH     = 32,
    parameter  int LINES      = 128,
    localparam int INDEXWIDTH = $clog2(LINES),
    localparam int TAGWIDTH   = AWIDTH - INDEXWIDTH,
    localparam int ENTRYWIDTH = DWIDTH + TAGWIDTH + 1,
    localparam int CACHEWIDTH = 1 + 2 * ENTRYWIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic [AWIDTH-1:0]     ra0,
    input  logic                  re0,
    output logic [DWIDTH-1:0]     dout0,
    output logic                  hit0,
    input  logic [AWIDTH-1:0]     ra1,
    input  logic                  re1,
    output logic [DWIDTH-1:0]     dout1,
    output logic                  hit1,
    input  logic [AWIDTH-1:0]     wa,
    output logic [CACHEWIDTH-1:0] line_out,
    input  logic                  we,
`ifdef BP_LINE_STORE_STATS_EN
    output logic [31:0]           lookups,
    output logic [31:0]           hits,
`endif
    input  logic [CACHEWIDTH-1:0] line_in
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [INDEXWIDTH-1:0] clr_idx_q, clr_idx_d;
    logic [CACHEWIDTH-1:0] mem_q [LINES];

    logic                  w_ready;
    logic                  w_wr_en;
    logic [INDEXWIDTH-1:0] w_wr_idx;
    logic [CACHEWIDTH-1:0] w_wr_data;
    logic [CACHEWIDTH-1:0] w_line0, w_line1, w_linew;
    logic [DWIDTH:0]       w_res0, w_res1;

    assign w_ready = (state_q == S_RUN);
    assign ready   = w_ready;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == S_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == INDEXWIDTH'(LINES - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // The sweep owns the write port until RUN; external writes are dropped.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = wa[INDEXWIDTH-1:0];
        w_wr_data = line_in;
        if (state_q == S_CLEAR) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = clr_idx_q;
            w_wr_data = '0;
        end else if (we) begin
            w_wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            mem_q[w_wr_idx] <= w_wr_data;
        end
    end

    // Returns {hit, data}; entry1 takes priority when both ways match.
    function automatic logic [DWIDTH:0] f_lookup(
        input logic [ENTRYWIDTH-1:0] e1,
        input logic [ENTRYWIDTH-1:0] e2,
        input logic [TAGWIDTH-1:0]   tag
    );
        logic h1, h2;
        h1 = e1[0] && (e1[TAGWIDTH:1] == tag);
        h2 = e2[0] && (e2[TAGWIDTH:1] == tag);
        if (h1) begin
            f_lookup = {1'b1, e1[ENTRYWIDTH-1:TAGWIDTH+1]};
        end else if (h2) begin
            f_lookup = {1'b1, e2[ENTRYWIDTH-1:TAGWIDTH+1]};
        end else begin
            f_lookup = '0;
        end
    endfunction

    assign w_line0 = mem_q[ra0[INDEXWIDTH-1:0]];
    assign w_line1 = mem_q[ra1[INDEXWIDTH-1:0]];
    assign w_linew = mem_q[wa[INDEXWIDTH-1:0]];

    assign w_res0 = f_lookup(w_line0[ENTRYWIDTH-1:0], w_line0[2*ENTRYWIDTH-1:ENTRYWIDTH],
                             ra0[AWIDTH-1:INDEXWIDTH]);
    assign w_res1 = f_lookup(w_line1[ENTRYWIDTH-1:0], w_line1[2*ENTRYWIDTH-1:ENTRYWIDTH],
                             ra1[AWIDTH-1:INDEXWIDTH]);

    assign hit0     = w_ready & w_res0[DWIDTH];
    assign dout0    = w_ready ? w_res0[DWIDTH-1:0] : '0;
    assign hit1     = w_ready & w_res1[DWIDTH];
    assign dout1    = w_ready ? w_res1[DWIDTH-1:0] : '0;
    assign line_out = w_ready ? w_linew : '0;

`ifdef BP_LINE_STORE_STATS_EN
    logic [31:0] lookups_q, lookups_d;
    logic [31:0] hits_q, hits_d;
    logic [32:0] w_lk_sum, w_ht_sum;

    assign w_lk_sum = {1'b0, lookups_q} + 33'(re0) + 33'(re1);
    assign w_ht_sum = {1'b0, hits_q} + 33'(re0 & hit0) + 33'(re1 & hit1);

    always_comb begin
        lookups_d = lookups_q;
        hits_d    = hits_q;
        if (w_ready) begin
            lookups_d = w_lk_sum[32] ? 32'hFFFF_FFFF : w_lk_sum[31:0];
            hits_d    = w_ht_sum[32] ? 32'hFFFF_FFFF : w_ht_sum[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else begin
            lookups_q <= lookups_d;
            hits_q    <= hits_d;
        end
    end

    assign lookups = lookups_q;
    assign hits    = hits_q;

    logic w_unused;
    assign w_unused = ^wa[AWIDTH-1:INDEXWIDTH];
`else
    logic w_unused;
    assign w_unused = ^{wa[AWIDTH-1:INDEXWIDTH], re0, re1};
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_line_store.sv
`default_nettype none
// Directed bench for bp_line_store: clear sweep timing, lookup table vectors,
// write/read ordering, and reset restart mid-sweep.
module tb_bp_line_store;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LN = 128;
    localparam int IW = 7;
    localparam int TW = AW - IW;
    localparam int EW = DW + TW + 1;
    localparam int CW = 1 + 2 * EW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready;
    logic [AW-1:0] ra0 = '0, ra1 = '0, wa = '0;
    logic          re0 = 1'b0, re1 = 1'b0, we = 1'b0;
    logic [DW-1:0] dout0, dout1;
    logic          hit0, hit1;
    logic [CW-1:0] line_out;
    logic [CW-1:0] line_in = '0;
`ifdef BP_LINE_STORE_STATS_EN
    logic [31:0]   lookups, hits;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bp_line_store #(.AWIDTH(AW), .DWIDTH(DW), .LINES(LN)) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .ra0      (ra0),
        .re0      (re0),
        .dout0    (dout0),
        .hit0     (hit0),
        .ra1      (ra1),
        .re1      (re1),
        .dout1    (dout1),
        .hit1     (hit1),
        .wa       (wa),
        .line_out (line_out),
        .we       (we),
`ifdef BP_LINE_STORE_STATS_EN
        .lookups  (lookups),
        .hits     (hits),
`endif
        .line_in  (line_in)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk_e(input logic [DW-1:0] d, input logic [TW-1:0] t,
                                           input logic v);
        return {d, t, v};
    endfunction

    function automatic logic [CW-1:0] mk_l(input logic f, input logic [EW-1:0] e2,
                                           input logic [EW-1:0] e1);
        return {f, e2, e1};
    endfunction

    typedef struct {
        logic [AW-1:0] ra0, ra1, wa;
        logic          we;
        logic [CW-1:0] lin;
        logic          h0;
        logic [DW-1:0] d0;
        logic          h1;
        logic [DW-1:0] d1;
        logic [CW-1:0] lout;
    } vec_t;

    vec_t vecs [10];

    // Waits for ready with a bound; returns the number of negedges waited.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
            if (!ready) begin
                chk("idle_hit0", {127'b0, hit0}, 128'd0);
                chk("idle_line_out", 128'(line_out), 128'd0);
            end
        end
    endtask

    initial begin
        logic [CW-1:0] l1, l2, l3, l4, l5;
        int cnt;

        l1 = mk_l(1'b0, '0, mk_e(32'hDEAD_BEEF, 25'd1, 1'b1));
        l2 = mk_l(1'b1, mk_e(32'h22, 25'd2, 1'b1), mk_e(32'h11, 25'd1, 1'b1));
        l3 = mk_l(1'b0, mk_e(32'hBBBB, 25'd3, 1'b1), mk_e(32'hAAAA, 25'd3, 1'b1));
        l4 = mk_l(1'b0, '0, mk_e(32'h1234, 25'd0, 1'b0));
        l5 = mk_l(1'b0, mk_e(32'h55, 25'd1, 1'b1), mk_e(32'h66, 25'd3, 1'b1));

        //          ra0      ra1      wa       we  lin h0 d0            h1 d1     lout
        vecs[0] = '{32'h085, 32'h105, 32'h085, 1, l1, 0, 0,            0, 0,     '0};
        vecs[1] = '{32'h085, 32'h105, 32'h105, 0, '0, 1, 32'hDEADBEEF, 0, 0,     l1};
        vecs[2] = '{32'h085, 32'h105, 32'h105, 1, l2, 1, 32'hDEADBEEF, 0, 0,     l1};
        vecs[3] = '{32'h085, 32'h105, 32'h105, 0, '0, 1, 32'h11,       1, 32'h22, l2};
        vecs[4] = '{32'h187, 32'h007, 32'h007, 1, l3, 0, 0,            0, 0,     '0};
        vecs[5] = '{32'h187, 32'h007, 32'h009, 1, l4, 1, 32'hAAAA,     0, 0,     '0};
        vecs[6] = '{32'h009, 32'h187, 32'h009, 0, '0, 0, 0,            1, 32'hAAAA, l4};
        vecs[7] = '{32'h000, 32'h07F, 32'h07F, 0, '0, 0, 0,            0, 0,     '0};
        vecs[8] = '{32'h085, 32'h105, 32'h085, 1, l5, 1, 32'h11,       1, 32'h22, l2};
        vecs[9] = '{32'h085, 32'h105, 32'h005, 0, '0, 1, 32'h55,       0, 0,     l5};

        // Reset held three cycles, with a write attempt that must be ignored.
        we = 1'b1; wa = 32'h0; line_in = l1;
        repeat (3) @(negedge clk);
        chk("rst_ready", {127'b0, ready}, 128'd0);
        chk("rst_hit0", {127'b0, hit0}, 128'd0);
        rst = 1'b0;
        wait_ready(cnt);
        chk("sweep_len", 128'(cnt), 128'd128);
        we = 1'b0;
        #1;
        chk("post_sweep_line0", 128'(line_out), 128'd0);
        chk("post_sweep_hit0", {127'b0, hit0}, 128'd0);
        chk("post_sweep_dout0", 128'(dout0), 128'd0);

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ra0 = vecs[i].ra0; ra1 = vecs[i].ra1; wa = vecs[i].wa;
            we = vecs[i].we; line_in = vecs[i].lin;
            #1;
            chk($sformatf("v%0d_hit0", i), {127'b0, hit0}, {127'b0, vecs[i].h0});
            chk($sformatf("v%0d_dout0", i), 128'(dout0), 128'(vecs[i].d0));
            chk($sformatf("v%0d_hit1", i), {127'b0, hit1}, {127'b0, vecs[i].h1});
            chk($sformatf("v%0d_dout1", i), 128'(dout1), 128'(vecs[i].d1));
            chk($sformatf("v%0d_line_out", i), 128'(line_out), 128'(vecs[i].lout));
        end
        @(negedge clk);
        we = 1'b0;

        // Reset from RUN, then a second reset 60 cycles into the sweep.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("mid_sweep_ready", {127'b0, ready}, 128'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        we = 1'b1; wa = 32'h085; line_in = l1; ra0 = 32'h085;
        wait_ready(cnt);
        chk("restart_sweep_len", 128'(cnt), 128'd128);
        we = 1'b0;
        #1;
        chk("restart_hit0", {127'b0, hit0}, 128'd0);
        chk("restart_line_out", 128'(line_out), 128'd0);

`ifdef BP_LINE_STORE_STATS_EN
        chk("stats_lookups_rst", 128'(lookups), 128'd0);
        @(negedge clk);
        we = 1'b1; wa = 32'h085; line_in = l1;
        @(negedge clk);
        we = 1'b0; ra0 = 32'h085; ra1 = 32'h105; re0 = 1'b1; re1 = 1'b1;
        repeat (10) @(negedge clk);
        re0 = 1'b0; re1 = 1'b0;
        #1;
        chk("stats_lookups", 128'(lookups), 128'd20);
        chk("stats_hits", 128'(hits), 128'd10);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
